// File: rtl/latency_probe_pkg.sv
// latency_probe_pkg
//   Shared definitions for the latency probe receiver:
//   - receiver FSM state encoding
//   - bit offsets of the transmit stamp and the "has time" flag in tuser
//   - default parameter values used by latency_probe_rx and latency_stat_acc
package latency_probe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BODY   = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  // tuser layout: {header[63:0], 8'b0, tx_stamp[27:0], aux[27:0]}
  localparam int STAMP_LSB    = 28;
  localparam int STAMP_MSB    = 55;
  localparam int HAS_TIME_BIT = 125;

  localparam int DEF_TS_WIDTH   = 28;
  localparam int DEF_CNT_WIDTH  = 32;
  localparam int DEF_SUM_WIDTH  = 48;
  localparam int DEF_TIMEOUT    = 1024;
  localparam int DEF_HIST_SHIFT = 4;
  localparam int ERR_WIDTH      = 16;

endpackage

// File: rtl/latency_stat_acc.sv
// latency_stat_acc
//   Latency statistics accumulator: last/min/max latency, saturating latency
//   sum, saturating packet counter and saturating error counter.
//   Ports:
//     clk_i      - clock (rising edge)
//     rst_i      - asynchronous active-high reset
//     clear_i    - synchronous clear; has priority over update_i/err_inc_i
//     update_i   - fold sample_i into the statistics this cycle
//     err_inc_i  - increment the error counter this cycle
//     sample_i   - latency sample
//     last_o/min_o/max_o/sum_o/pkt_o/err_o - registered statistics
module latency_stat_acc
  import latency_probe_pkg::*;
#(
  parameter int TS_WIDTH  = DEF_TS_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int SUM_WIDTH = DEF_SUM_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 update_i,
  input  logic                 err_inc_i,
  input  logic [TS_WIDTH-1:0]  sample_i,
  output logic [TS_WIDTH-1:0]  last_o,
  output logic [TS_WIDTH-1:0]  min_o,
  output logic [TS_WIDTH-1:0]  max_o,
  output logic [SUM_WIDTH-1:0] sum_o,
  output logic [CNT_WIDTH-1:0] pkt_o,
  output logic [ERR_WIDTH-1:0] err_o
);

  localparam int SUM_EXT_W = SUM_WIDTH + 1;

  logic [TS_WIDTH-1:0]  last_q;
  logic [TS_WIDTH-1:0]  min_q;
  logic [TS_WIDTH-1:0]  max_q;
  logic [SUM_WIDTH-1:0] sum_q;
  logic [CNT_WIDTH-1:0] pkt_q;
  logic [ERR_WIDTH-1:0] err_q;

  // One extra bit catches the carry; a carry pins the sum at all-ones.
  function automatic logic [SUM_WIDTH-1:0] sat_add_sum(
    input logic [SUM_WIDTH-1:0] acc,
    input logic [TS_WIDTH-1:0]  val
  );
    logic [SUM_EXT_W-1:0] s;
    s = {1'b0, acc} + SUM_EXT_W'(val);
    return s[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : s[SUM_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] c);
    return (c == {CNT_WIDTH{1'b1}}) ? c : c + CNT_WIDTH'(1);
  endfunction

  function automatic logic [ERR_WIDTH-1:0] sat_inc_err(input logic [ERR_WIDTH-1:0] c);
    return (c == {ERR_WIDTH{1'b1}}) ? c : c + ERR_WIDTH'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= '0;
      min_q  <= '1;
      max_q  <= '0;
      sum_q  <= '0;
      pkt_q  <= '0;
      err_q  <= '0;
    end else if (clear_i) begin
      last_q <= '0;
      min_q  <= '1;
      max_q  <= '0;
      sum_q  <= '0;
      pkt_q  <= '0;
      err_q  <= '0;
    end else begin
      if (update_i) begin
        last_q <= sample_i;
        if (sample_i < min_q) min_q <= sample_i;
        if (sample_i > max_q) max_q <= sample_i;
        sum_q  <= sat_add_sum(sum_q, sample_i);
        pkt_q  <= sat_inc_cnt(pkt_q);
      end
      if (err_inc_i) err_q <= sat_inc_err(err_q);
    end
  end

  assign last_o = last_q;
  assign min_o  = min_q;
  assign max_o  = max_q;
  assign sum_o  = sum_q;
  assign pkt_o  = pkt_q;
  assign err_o  = err_q;

endmodule

// File: rtl/latency_probe_rx.sv
// latency_probe_rx
//   AXI-stream sink that measures per-packet latency from a transmit stamp
//   carried in tuser against a free-running timer, and keeps statistics.
//   Optional feature macro: LATENCY_PROBE_HIST_EN adds an 8-bin latency
//   histogram output (hist_bins) with parameter HIST_SHIFT.
//   Ports:
//     clk, reset            - clock, asynchronous active-high reset
//     m_axis_data_tdata     - payload (consumed only)
//     m_axis_data_tuser     - {header[63:0], 8'b0, tx_stamp[27:0], aux[27:0]}
//     m_axis_data_tlast/tvalid/tready - AXI-stream handshake
//     timer                 - free-running time base
//     clear                 - single-cycle synchronous statistics clear
//     lat_last/lat_min/lat_max/lat_sum/pkt_count/err_count - statistics
//     hist_bins             - (LATENCY_PROBE_HIST_EN only) 8 x 16-bit bins
module latency_probe_rx
  import latency_probe_pkg::*;
#(
  parameter int TS_WIDTH   = DEF_TS_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int SUM_WIDTH  = DEF_SUM_WIDTH,
`ifdef LATENCY_PROBE_HIST_EN
  parameter int HIST_SHIFT = DEF_HIST_SHIFT,
`endif
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          m_axis_data_tdata,
  input  logic [127:0]         m_axis_data_tuser,
  input  logic                 m_axis_data_tlast,
  input  logic                 m_axis_data_tvalid,
  output logic                 m_axis_data_tready,
  input  logic [63:0]          timer,
  input  logic                 clear,
  output logic [TS_WIDTH-1:0]  lat_last,
  output logic [TS_WIDTH-1:0]  lat_min,
  output logic [TS_WIDTH-1:0]  lat_max,
  output logic [SUM_WIDTH-1:0] lat_sum,
  output logic [CNT_WIDTH-1:0] pkt_count,
`ifdef LATENCY_PROBE_HIST_EN
  output logic [8*16-1:0]      hist_bins,
`endif
  output logic [15:0]          err_count
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                stamped_q;
  logic [TS_WIDTH-1:0] lat_cur_q;

  logic                beat;
  logic                capture;
  logic                timeout;
  logic                stat_upd;
  logic                err_inc;
  logic [TS_WIDTH-1:0] stamp;
  logic [TS_WIDTH-1:0] lat_new;

  // Payload and the unused tuser/timer bits are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{m_axis_data_tdata, m_axis_data_tuser, timer};

  assign m_axis_data_tready = (state_q != ST_UPDATE);
  assign beat    = m_axis_data_tvalid & m_axis_data_tready;
  assign stamp   = TS_WIDTH'(m_axis_data_tuser[STAMP_MSB:STAMP_LSB]);
  // Modular subtraction: a timer that wrapped past the stamp still yields
  // the true elapsed time.
  assign lat_new = timer[TS_WIDTH-1:0] - stamp;

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          capture = 1'b1;
          idle_d  = '0;
          state_d = m_axis_data_tlast ? ST_UPDATE : ST_BODY;
        end
      end
      ST_BODY: begin
        if (beat) begin
          idle_d = '0;
          if (m_axis_data_tlast) state_d = ST_UPDATE;
        end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
          // This idle cycle brings the count to TIMEOUT: drop the packet.
          timeout = 1'b1;
          idle_d  = '0;
          state_d = ST_IDLE;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idle_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idle_q    <= '0;
      stamped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      if (capture) stamped_q <= m_axis_data_tuser[HAS_TIME_BIT];
    end
  end

  // Latency sample is pure data; it is only consumed in UPDATE after a capture.
  always_ff @(posedge clk) begin
    if (capture) lat_cur_q <= lat_new;
  end

  assign stat_upd = (state_q == ST_UPDATE) &  stamped_q;
  assign err_inc  = ((state_q == ST_UPDATE) & ~stamped_q) | timeout;

  latency_stat_acc #(
    .TS_WIDTH  (TS_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .SUM_WIDTH (SUM_WIDTH)
  ) u_acc (
    .clk_i     (clk),
    .rst_i     (reset),
    .clear_i   (clear),
    .update_i  (stat_upd),
    .err_inc_i (err_inc),
    .sample_i  (lat_cur_q),
    .last_o    (lat_last),
    .min_o     (lat_min),
    .max_o     (lat_max),
    .sum_o     (lat_sum),
    .pkt_o     (pkt_count),
    .err_o     (err_count)
  );

`ifdef LATENCY_PROBE_HIST_EN
  logic [15:0]         bins_q [8];
  logic [TS_WIDTH-1:0] hist_shifted;
  logic [2:0]          hist_idx;

  always_comb begin
    hist_shifted = lat_cur_q >> HIST_SHIFT;
    hist_idx     = (hist_shifted > TS_WIDTH'(7)) ? 3'd7 : hist_shifted[2:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) bins_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 8; i++) bins_q[i] <= '0;
    end else if (stat_upd && (bins_q[hist_idx] != 16'hFFFF)) begin
      bins_q[hist_idx] <= bins_q[hist_idx] + 16'd1;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_hist_out
    assign hist_bins[g*16 +: 16] = bins_q[g];
  end
`endif

endmodule

// File: tb/tb_latency_probe_rx.sv
module tb_latency_probe_rx;
  import latency_probe_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  m_axis_data_tdata;
  logic [127:0] m_axis_data_tuser;
  logic         m_axis_data_tlast;
  logic         m_axis_data_tvalid;
  logic         m_axis_data_tready;
  logic [63:0]  timer;
  logic         clear;
  logic [27:0]  lat_last, lat_min, lat_max;
  logic [47:0]  lat_sum;
  logic [31:0]  pkt_count;
  logic [15:0]  err_count;
`ifdef LATENCY_PROBE_HIST_EN
  logic [127:0] hist_bins;
`endif

  latency_probe_rx dut (
    .clk                (clk),
    .reset              (reset),
    .m_axis_data_tdata  (m_axis_data_tdata),
    .m_axis_data_tuser  (m_axis_data_tuser),
    .m_axis_data_tlast  (m_axis_data_tlast),
    .m_axis_data_tvalid (m_axis_data_tvalid),
    .m_axis_data_tready (m_axis_data_tready),
    .timer              (timer),
    .clear              (clear),
    .lat_last           (lat_last),
    .lat_min            (lat_min),
    .lat_max            (lat_max),
    .lat_sum            (lat_sum),
    .pkt_count          (pkt_count),
`ifdef LATENCY_PROBE_HIST_EN
    .hist_bins          (hist_bins),
`endif
    .err_count          (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [27:0] last;
    logic [27:0] mn;
    logic [27:0] mx;
    logic [47:0] sum;
    logic [31:0] pkt;
    logic [15:0] err;
  } snap_t;

  snap_t sb[$];
  snap_t m;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_snap(input string tag, input snap_t e);
    chk({tag, "_last"}, 64'(lat_last),  64'(e.last));
    chk({tag, "_min"},  64'(lat_min),   64'(e.mn));
    chk({tag, "_max"},  64'(lat_max),   64'(e.mx));
    chk({tag, "_sum"},  64'(lat_sum),   64'(e.sum));
    chk({tag, "_pkt"},  64'(pkt_count), 64'(e.pkt));
    chk({tag, "_err"},  64'(err_count), 64'(e.err));
  endtask

  task automatic model_clear();
    m.last = '0; m.mn = '1; m.mx = '0; m.sum = '0; m.pkt = '0; m.err = '0;
  endtask

  task automatic model_pkt(input logic [27:0] stamp, input logic [63:0] tmr, input logic has);
    logic [27:0] lat;
    lat = tmr[27:0] - stamp;
    if (has) begin
      m.last = lat;
      if (lat < m.mn) m.mn = lat;
      if (lat > m.mx) m.mx = lat;
      m.sum = m.sum + 48'(lat);
      m.pkt = m.pkt + 32'd1;
    end else begin
      m.err = m.err + 16'd1;
    end
  endtask

  task automatic send_beat(input logic [27:0] stamp, input logic has, input logic last,
                           input logic [63:0] tmr, input logic clr);
    logic [63:0] hdr;
    @(negedge clk);
    hdr = {$urandom, $urandom};
    hdr[61] = has;
    m_axis_data_tuser  = {hdr, 8'h00, stamp, 28'($urandom)};
    m_axis_data_tdata  = $urandom;
    m_axis_data_tlast  = last;
    m_axis_data_tvalid = 1'b1;
    timer              = tmr;
    clear              = clr;
  endtask

  // After the tlast beat: check the one-cycle bubble, then the stats update.
  task automatic end_pkt(input string tag);
    snap_t e;
    @(negedge clk);
    m_axis_data_tvalid = 1'b0;
    m_axis_data_tlast  = 1'b0;
    clear              = 1'b0;
    chk({tag, "_bubble"}, 64'(m_axis_data_tready), 64'd0);
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(m_axis_data_tready), 64'd1);
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_snap(tag, e);
    end
  endtask

  task automatic run_pkt(input string tag, input int n, input logic [27:0] stamp,
                         input logic has, input logic [63:0] tmr, input int clr_beat);
    for (int i = 0; i < n; i++)
      send_beat((i == 0) ? stamp : stamp ^ 28'(i * 123), has, (i == n - 1),
                tmr + 64'(i * 7), (i == clr_beat));
    if (clr_beat >= 0) model_clear();
    model_pkt(stamp, tmr, has);
    sb.push_back(m);
    end_pkt(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0;
    m_axis_data_tvalid = 1'b0; m_axis_data_tlast = 1'b0;
    m_axis_data_tdata = '0; m_axis_data_tuser = '0; timer = '0;
    model_clear();
    repeat (2) @(negedge clk);
    chk_snap("rst", m);
    chk("rst_tready", 64'(m_axis_data_tready), 64'd1);
    reset = 1'b0;

    // single-beat stamped packet: latency 30
    run_pkt("stamp1", 1, 28'd100, 1'b1, 64'd130, -1);
    chk("stamp1_last30", 64'(lat_last), 64'd30);

    // wrap-around of the subtraction, upper timer bits must be ignored
    run_pkt("wrap", 1, 28'hFFFFFF0, 1'b1, {36'h5A5A5A5A5, 28'h0000010}, -1);
    chk("wrap_last", 64'(lat_last), 64'h20);

    // standalone clear
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
    chk_snap("clear", m);

    // three 4-beat packets
    run_pkt("p50", 4, 28'h1234567, 1'b1, 64'h1234567 + 64'd50, -1);
    run_pkt("p10", 4, 28'h0ABCDEF, 1'b1, 64'h0ABCDEF + 64'd10, -1);
    run_pkt("p90", 4, 28'h7000000, 1'b1, 64'h7000000 + 64'd90, -1);
    chk("multi_min", 64'(lat_min), 64'd10);
    chk("multi_max", 64'(lat_max), 64'd90);
    chk("multi_sum", 64'(lat_sum), 64'd150);
    chk("multi_pkt", 64'(pkt_count), 64'd3);
    chk("multi_err", 64'(err_count), 64'd0);

    // unstamped packet
    run_pkt("unst", 3, 28'd77, 1'b0, 64'd999, -1);
    chk("unst_err", 64'(err_count), 64'd1);
    chk("unst_pkt", 64'(pkt_count), 64'd3);

    // timeout: first beat, then TIMEOUT idle cycles
    send_beat(28'd1000, 1'b1, 1'b0, 64'd2000, 1'b0);
    @(negedge clk); m_axis_data_tvalid = 1'b0;
    repeat (DEF_TIMEOUT - 1) @(negedge clk);
    chk("to_before_err", 64'(err_count), 64'd1);
    @(negedge clk);
    chk("to_err", 64'(err_count), 64'd2);
    chk("to_rdy", 64'(m_axis_data_tready), 64'd1);
    m.err = m.err + 16'd1;

    // back in IDLE: next packet is measured from its own first beat
    run_pkt("post_to", 2, 28'd500, 1'b1, 64'd505, -1);
    chk("post_to_min", 64'(lat_min), 64'd5);

    // clear coinciding with a timeout: clear wins
    send_beat(28'd1000, 1'b1, 1'b0, 64'd2000, 1'b0);
    @(negedge clk); m_axis_data_tvalid = 1'b0;
    repeat (DEF_TIMEOUT - 1) @(negedge clk);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
    chk_snap("to_clr", m);
    chk("to_clr_rdy", 64'(m_axis_data_tready), 64'd1);

    // clear in the UPDATE cycle discards that packet
    run_pkt("pre_cu", 1, 28'd300, 1'b1, 64'd340, -1);
    send_beat(28'd300, 1'b1, 1'b1, 64'd355, 1'b0);
    @(negedge clk);
    m_axis_data_tvalid = 1'b0; m_axis_data_tlast = 1'b0;
    clear = 1'b1;
    chk("cu_bubble", 64'(m_axis_data_tready), 64'd0);
    @(negedge clk); clear = 1'b0;
    model_clear();
    chk_snap("clr_upd", m);

    // next packet latency 7, with a clear pulse mid-packet (in BODY)
    run_pkt("lat7", 3, 28'd40, 1'b1, 64'd47, 1);
    chk("lat7_min", 64'(lat_min), 64'd7);
    chk("lat7_pkt", 64'(pkt_count), 64'd1);

    // reset mid-packet after beat 2 of 5
    send_beat(28'd111, 1'b1, 1'b0, 64'd900, 1'b0);
    send_beat(28'd222, 1'b1, 1'b0, 64'd910, 1'b0);
    @(negedge clk); m_axis_data_tvalid = 1'b0;
    reset = 1'b1;
    #1;
    model_clear();
    chk_snap("rst_mid", m);
    chk("rst_mid_rdy", 64'(m_axis_data_tready), 64'd1);
    @(negedge clk); reset = 1'b0;
    send_beat(28'd600, 1'b1, 1'b0, 64'd612, 1'b0);
    send_beat(28'd700, 1'b1, 1'b0, 64'd620, 1'b0);
    send_beat(28'd800, 1'b1, 1'b1, 64'd630, 1'b0);
    model_pkt(28'd600, 64'd612, 1'b1);
    sb.push_back(m);
    end_pkt("after_rst");
    chk("after_rst_last", 64'(lat_last), 64'd12);
    chk("after_rst_pkt", 64'(pkt_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/latency_probe_rx.md
LATENCY_PROBE_RX -- requirements
Module: latency_probe_rx

Interface
REQ-001 Parameter TS_WIDTH, default 28: timestamp field width carried in tuser.
REQ-002 Parameter CNT_WIDTH, default 32: packet counter width.
REQ-003 Parameter SUM_WIDTH, default 48: latency accumulator width.
REQ-004 Parameter TIMEOUT, default 1024: maximum idle cycles allowed inside a packet.
REQ-005 Port clk, input, 1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port m_axis_data_tdata, input, 32: payload; consumed, not inspected.
REQ-008 Port m_axis_data_tuser, input, 128: {header[63:0], 8'b0, tx_stamp[27:0], aux[27:0]}.
REQ-009 Port m_axis_data_tlast / m_axis_data_tvalid, input, 1 each: AXI-stream last and valid.
REQ-010 Port m_axis_data_tready, output, 1: AXI-stream ready.
REQ-011 Port timer, input, 64: free-running time base, in the same units as tx_stamp.
REQ-012 Port clear, input, 1: synchronous single-cycle pulse that zeroes the statistics.
REQ-013 Ports lat_last / lat_min / lat_max, output, TS_WIDTH each: latency of the last packet, minimum latency, maximum latency.
REQ-014 Port lat_sum, output, SUM_WIDTH: accumulated latency.
REQ-015 Port pkt_count, output, CNT_WIDTH: number of packets with a valid stamp.
REQ-016 Port err_count, output, 16: number of unstamped packets plus timed-out packets.

Function
REQ-017 The block SHALL implement a three-state FSM with states IDLE, BODY and UPDATE.
REQ-018 m_axis_data_tready SHALL be 1 in IDLE and BODY, and 0 in UPDATE; this gives exactly one bubble per packet.
REQ-019 A beat SHALL occur only when tvalid and tready are both 1.
REQ-020 First beat of a packet, in IDLE: the block SHALL register lat_cur = (timer[27:0] - tuser[55:28]) mod 2^TS_WIDTH and register stamped = tuser[125].
- Wrap-around of the subtraction is the intended result.
REQ-021 IDLE SHALL go to UPDATE if the first beat has tlast=1, and to BODY otherwise.
REQ-022 BODY SHALL go to UPDATE on a beat with tlast=1.
REQ-023 UPDATE SHALL last exactly one cycle and then go to IDLE.
REQ-024 In UPDATE with stamped=1, the block SHALL:
- set lat_last = lat_cur;
- set lat_min = min(lat_min, lat_cur);
- set lat_max = max(lat_max, lat_cur);
- add lat_cur to lat_sum;
- increment pkt_count.
REQ-025 In UPDATE with stamped=0, the block SHALL increment err_count and leave the latency statistics unchanged.
REQ-026 In BODY, an idle counter SHALL increment on every cycle without a beat and reset to 0 on every beat.
REQ-027 When the idle counter reaches TIMEOUT, the block SHALL increment err_count, discard the packet and go to IDLE.
REQ-028 pkt_count, err_count and lat_sum SHALL saturate at all-ones and never wrap.
REQ-029 Statistics outputs SHALL be registered and SHALL update on the clock edge that ends UPDATE, i.e. one cycle after the tlast beat.
REQ-030 clear SHALL set:
- lat_min to all-ones;
- lat_max, lat_last, lat_sum, pkt_count and err_count to 0.
REQ-031 clear SHALL NOT alter the FSM state; a packet in flight SHALL complete normally.
REQ-032 If clear and UPDATE coincide, clear SHALL win and that packet's update SHALL be discarded.
REQ-033 If clear and a timeout coincide, clear SHALL win.

Reset
REQ-034 Reset SHALL asynchronously force:
- FSM = IDLE;
- idle counter = 0;
- statistics to the REQ-030 values;
- tready = 1 (IDLE).
REQ-035 Reset asserted mid-packet SHALL abandon the packet; the remaining beats after release SHALL be treated as a new packet.

Configuration
REQ-036 Macro LATENCY_PROBE_HIST_EN, when defined, SHALL add output hist_bins[8*16-1:0]: eight saturating 16-bit bins, bin index = min(lat_cur >> HIST_SHIFT, 7).
- Parameter HIST_SHIFT, default 4.
- A bin SHALL be updated only in UPDATE with stamped=1.
- clear and reset SHALL zero all bins.
REQ-037 When LATENCY_PROBE_HIST_EN is undefined, the histogram port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-038 Package latency_probe_pkg SHALL hold:
- the FSM state encoding;
- the tuser field offsets (STAMP_LSB=28, STAMP_MSB=55, HAS_TIME_BIT=125);
- the default parameter constants.
REQ-039 Sub-module latency_stat_acc SHALL hold the min/max/sum/count saturating update logic, with update, clear and sample inputs.

Verification
REQ-040 Stamp, single beat: single-beat packet, tuser[55:28]=100, timer=130, tuser[125]=1 -> next cycle lat_last=30, lat_min=30, lat_max=30, lat_sum=30, pkt_count=1; tready low for one cycle after the beat.
REQ-041 Wrap-around: stamp=0xFFFFFF0, timer[27:0]=0x10 -> lat_last=0x20.
REQ-042 Multi-packet: three 4-beat packets with latencies 50, 10, 90 -> lat_min=10, lat_max=90, lat_sum=150, pkt_count=3, err_count=0.
REQ-043 Unstamped and timeout:
- packet with tuser[125]=0 -> err_count=1, pkt_count unchanged;
- then a 2-beat packet whose tvalid drops for TIMEOUT cycles after the first beat -> err_count=2, FSM returns to IDLE.
REQ-044 Clear collision: clear pulsed in the UPDATE cycle -> all statistics at clear values, packet not counted; the next packet with latency 7 -> lat_min=7, pkt_count=1.
REQ-045 Reset mid-packet: reset asserted after beat 2 of 5 -> outputs at reset values immediately; beats 3-5 after release -> pkt_count=1, with latency computed from beat 3.
